// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: settles a raw ripple counter into clk, tracks +/-1 steps and extends it with a wrap word
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active-low
//   cnt_in, updown_in   raw counter value and direction, asynchronous to clk
//   clr                 synchronous return to INIT; clears the wrap word and the filter
//   valid               q_stable/ext_count hold an accepted value
//   q_stable            last accepted counter value
//   ext_count           {ext_hi, q_stable}
//   wrap_up, wrap_dn    one-cycle pulses on an accepted MAX->0 / 0->MAX step
//   step_err, dir_err   one-cycle pulses on an illegal step / a legal step against updown
module ripple_count_monitor #(
   parameter int CNT_W         = 4,
   parameter int EXT_W         = 8,
   parameter int STABLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CNT_W-1:0]       cnt_in,
   input  logic                   updown_in,
   input  logic                   clr,
   output logic                   valid,
   output logic [CNT_W-1:0]       q_stable,
   output logic [EXT_W+CNT_W-1:0] ext_count,
   output logic                   wrap_up,
   output logic                   wrap_dn,
   output logic                   step_err,
   output logic                   dir_err
);
   localparam int SC_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);
   localparam logic [SC_W-1:0] SC_ACC = SC_W'(STABLE_CYCLES - 1);
   typedef enum logic {INIT, TRACK} state_t;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] s1_cnt, s2_cnt, s2d_cnt, q_nxt, delta;
   logic             s1_ud, s2_ud;
   logic [2:0]       fill;
   logic [SC_W-1:0]  stab_cnt, stab_nxt;
   logic [EXT_W-1:0] ext_hi, ext_nxt;
   logic             same, settled, accept, trk_acc, is_up, is_dn;
   logic             wu_nxt, wd_nxt, se_nxt, de_nxt;
   // fill marks which pipeline stages hold real samples since reset, so the
   // reset zeros in s2/s2d are never mistaken for a settled counter value
   always_comb begin
      same      = fill[2] && (s2_cnt == s2d_cnt);
      stab_nxt  = !same ? '0 : (stab_cnt == SC_MAX) ? SC_MAX : stab_cnt + SC_W'(1);
      settled   = (STABLE_CYCLES == 1) ? fill[1] : same && (stab_nxt == SC_ACC);
      accept    = settled && (state == INIT || s2_cnt != q_stable);
      delta     = s2_cnt - q_stable;
      is_up     = delta == CNT_W'(1);
      is_dn     = delta == '1;
      state_nxt = clr ? INIT : accept ? TRACK : state;
      q_nxt     = (!clr && accept) ? s2_cnt : q_stable;
      trk_acc   = !clr && accept && state == TRACK;
      wu_nxt    = trk_acc && is_up && q_stable == '1;
      wd_nxt    = trk_acc && is_dn && q_stable == '0;
      se_nxt    = trk_acc && !is_up && !is_dn;
      de_nxt    = trk_acc && (is_up ? !s2_ud : is_dn && s2_ud);
      ext_nxt   = clr ? '0 : ext_hi + EXT_W'(wu_nxt) - EXT_W'(wd_nxt);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_cnt   <= '0;
         s2_cnt   <= '0;
         s2d_cnt  <= '0;
         s1_ud    <= 1'b0;
         s2_ud    <= 1'b0;
         fill     <= '0;
         stab_cnt <= '0;
         state    <= INIT;
         q_stable <= '0;
         ext_hi   <= '0;
         wrap_up  <= 1'b0;
         wrap_dn  <= 1'b0;
         step_err <= 1'b0;
         dir_err  <= 1'b0;
      end else begin
         s1_cnt   <= cnt_in;
         s2_cnt   <= s1_cnt;
         s2d_cnt  <= s2_cnt;
         s1_ud    <= updown_in;
         s2_ud    <= s1_ud;
         fill     <= {fill[1:0], 1'b1};
         stab_cnt <= clr ? '0 : stab_nxt;
         state    <= state_nxt;
         q_stable <= q_nxt;
         ext_hi   <= ext_nxt;
         wrap_up  <= wu_nxt;
         wrap_dn  <= wd_nxt;
         step_err <= se_nxt;
         dir_err  <= de_nxt;
      end
   end
   assign valid     = state == TRACK;
   assign ext_count = {ext_hi, q_stable};
endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor: directed and randomized checks of ripple_count_monitor against a sample-history model
module tb_ripple_count_monitor;
   logic        clk = 1'b0;
   logic        rst, updown_in, clr;
   logic [3:0]  cnt_in, q_stable;
   logic [11:0] ext_count;
   logic        valid, wrap_up, wrap_dn, step_err, dir_err;
   logic [3:0]  pv;
   int checks = 0, errs = 0;
   int n_wu = 0, n_wd = 0, n_se = 0, n_de = 0;
   int hist_c[3], hist_u[3];
   int run, m_q, m_ext;
   bit m_valid;
   bit [3:0] m_p;
   logic [11:0] exp_ext;
   int cur, b_wu, b_wd, b_se, b_de;

   ripple_count_monitor dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .updown_in(updown_in), .clr(clr),
      .valid(valid), .q_stable(q_stable), .ext_count(ext_count),
      .wrap_up(wrap_up), .wrap_dn(wrap_dn), .step_err(step_err), .dir_err(dir_err)
   );

   always #5 clk = ~clk;
   assign pv = {wrap_up, wrap_dn, step_err, dir_err};

   // history entries are the raw samples taken at past edges; -1 means no sample since reset
   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         hist_c[i] = -1;
         hist_u[i] = 0;
      end
      run = 0; m_q = 0; m_ext = 0; m_valid = 0; m_p = '0;
   endtask

   task automatic model_step();
      int v, u, d, run_new;
      bit eq, acc;
      v = hist_c[1];
      u = hist_u[1];
      eq = hist_c[2] >= 0 && hist_c[1] == hist_c[2];
      run_new = eq ? (run < 2 ? run + 1 : 2) : 0;
      acc = eq && run_new == 1 && (!m_valid || v != m_q);
      run = clr ? 0 : run_new;
      m_p = '0;
      if (clr) begin
         m_valid = 0;
         m_ext = 0;
      end else if (acc) begin
         if (m_valid) begin
            d = (v - m_q) & 15;
            if (d == 1) begin
               m_p[3] = m_q == 15;
               m_p[0] = u == 0;
               if (m_q == 15) m_ext = (m_ext + 1) % 256;
            end else if (d == 15) begin
               m_p[2] = m_q == 0;
               m_p[0] = u == 1;
               if (m_q == 0) m_ext = (m_ext + 255) % 256;
            end else m_p[1] = 1;
         end
         m_valid = 1;
         m_q = v;
      end
      hist_c[2] = hist_c[1]; hist_c[1] = hist_c[0]; hist_c[0] = int'(cnt_in);
      hist_u[2] = hist_u[1]; hist_u[1] = hist_u[0]; hist_u[0] = int'(updown_in);
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      exp_ext = {m_ext[7:0], m_q[3:0]};
      chk("cyc_ext", ext_count, exp_ext);
      chk("cyc_valid", 12'(valid), 12'(m_valid));
      chk("cyc_pulses", 12'(pv), 12'(m_p));
      n_wu += int'(wrap_up); n_wd += int'(wrap_dn);
      n_se += int'(step_err); n_de += int'(dir_err);
   endtask

   task automatic hold(input int v, input int n);
      cnt_in = 4'(v);
      repeat (n) tick();
   endtask

   task automatic init_at(input int v);
      clr = 1'b1;
      cnt_in = 4'(v);
      repeat (3) tick();
      clr = 1'b0;
      repeat (5) tick();
   endtask

   task automatic snap();
      b_wu = n_wu; b_wd = n_wd; b_se = n_se; b_de = n_de;
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; cnt_in = 4'd5; updown_in = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 12'(valid), 12'h0);
      chk("rst_ext", ext_count, 12'h000);
      chk("rst_pulses", 12'(pv), 12'h0);
      @(negedge clk) rst = 1'b1;
      snap();
      repeat (6) tick();
      chk("t1_valid", 12'(valid), 12'h1);
      chk("t1_ext", ext_count, 12'h005);
      chk("t1_no_pulse", 12'(n_wu + n_wd + n_se + n_de - b_wu - b_wd - b_se - b_de), 12'h0);

      snap();
      for (int v = 6; v <= 17; v++) hold(v % 16, 6);
      chk("t2_wrap_up_cnt", 12'(n_wu - b_wu), 12'h1);
      chk("t2_ext", ext_count, 12'h011);
      chk("t2_errs", 12'(n_se - b_se + n_de - b_de), 12'h0);

      updown_in = 1'b0;
      hold(0, 6);
      chk("t3_ext_010", ext_count, 12'h010);
      snap();
      hold(15, 6);
      chk("t3_wrap_dn_cnt", 12'(n_wd - b_wd), 12'h1);
      chk("t3_ext_00f", ext_count, 12'h00F);
      init_at(0);
      chk("t3_init0", ext_count, 12'h000);
      hold(15, 6);
      chk("t3_ext_fff", ext_count, 12'hFFF);

      updown_in = 1'b1;
      init_at(3);
      snap();
      updown_in = 1'b0;
      hold(4, 6);
      chk("t4_dir_err_cnt", 12'(n_de - b_de), 12'h1);
      chk("t4_q", 12'(q_stable), 12'h4);
      snap();
      hold(9, 6);
      chk("t4_step_err_cnt", 12'(n_se - b_se), 12'h1);
      chk("t4_ext", ext_count, 12'h009);

      updown_in = 1'b1;
      init_at(7);
      snap();
      hold(0, 1);
      hold(12, 1);
      hold(8, 3);
      chk("t5_before", ext_count, 12'h007);
      tick();
      chk("t5_after", ext_count, 12'h008);
      chk("t5_no_step_err", 12'(n_se - b_se), 12'h0);

      cnt_in = 4'd9;
      tick();
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("t6_rst_valid", 12'(valid), 12'h0);
      chk("t6_rst_ext", ext_count, 12'h000);
      @(negedge clk) rst = 1'b1;
      repeat (3) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t6_clr_valid", 12'(valid), 12'h0);
      chk("t6_clr_pulse", 12'(pv), 12'h0);
      tick();
      chk("t6_init_valid", 12'(valid), 12'h1);
      chk("t6_init_ext", ext_count, 12'h009);
      chk("t6_init_pulse", 12'(pv), 12'h0);

      cur = 9;
      for (int i = 0; i < 200; i++) begin
         bit up;
         up = $urandom_range(0, 1) == 1;
         cur = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : (cur + (up ? 1 : 15)) % 16;
         updown_in = ($urandom_range(0, 4) == 0) ? !up : up;
         clr = $urandom_range(0, 24) == 0;
         cnt_in = 4'(cur);
         tick();
         clr = 1'b0;
         repeat ($urandom_range(0, 5)) tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end
endmodule
